fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer_pkg.sv | 13 +
 rtl/fifo_rd_packer_tmo.sv | 28 ++
 rtl/fifo_rd_packer.sv | 90 +++++++++
 tb/tb_fifo_rd_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_rd_packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_DSIZE     = 8;
    localparam int DEF_NWORDS    = 4;
    localparam int DEF_TO_CYCLES = 16;

endpackage

// File: rtl/fifo_rd_packer_tmo.sv
// Idle counter for partial-packet flush. Only instantiated when
// FIFO_RD_PACKER_TIMEOUT_EN is defined.
module fifo_rd_packer_tmo #(
    parameter int TO_CYCLES = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic idle,
    input  logic clr,
    output logic fire
);

    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] cnt;

    // fire on the edge where the idle count would reach TO_CYCLES
    assign fire = idle && (cnt == TW'(TO_CYCLES - 1));

    // count consecutive idle cycles; any pop or non-idle cycle restarts
    always_ff @(posedge rclk) begin
        if (rrst || clr || !idle || fire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs NWORDS show-ahead FIFO words into one output packet.
// Optional partial flush on idle: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DSIZE     = DEF_DSIZE,
    parameter int NWORDS    = DEF_NWORDS,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic                         rempty,
    input  logic [DSIZE-1:0]             rdata,
    output logic                         rreq,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DSIZE*NWORDS-1:0]      m_data,
    output logic [$clog2(NWORDS+1)-1:0]  m_cnt
);

    localparam int IW = $clog2(NWORDS);
    localparam int CW = $clog2(NWORDS + 1);

    state_t                         state;
    logic [IW-1:0]                  idx;
    logic [NWORDS-1:0][DSIZE-1:0]   lanes;
    logic                           flush;

    // pop whenever filling and a head word is available
    assign rreq   = (state == FILL) && !rempty && !rrst;
    assign m_data = lanes;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    fifo_rd_packer_tmo #(
        .TO_CYCLES (TO_CYCLES)
    ) u_tmo (
        .rclk (rclk),
        .rrst (rrst),
        .idle ((state == FILL) && (idx != '0) && rempty),
        .clr  (rreq),
        .fire (flush)
    );
`else
    // partial packets wait indefinitely
    localparam int unused_to_cycles = TO_CYCLES;
    assign flush = 1'b0;
`endif

    // packer FSM: fill lanes, then hold the packet until accepted
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state   <= FILL;
            idx     <= '0;
            lanes   <= '0;
            m_valid <= 1'b0;
            m_cnt   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (rreq) begin
                        lanes[idx] <= rdata;
                        if (idx == IW'(NWORDS - 1)) begin
                            state   <= HOLD;
                            m_valid <= 1'b1;
                            m_cnt   <= CW'(NWORDS);
                            idx     <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (flush) begin
                        state   <= HOLD;
                        m_valid <= 1'b1;
                        m_cnt   <= CW'(idx);
                        idx     <= '0;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state   <= FILL;
                        m_valid <= 1'b0;
                        m_cnt   <= '0;
                        lanes   <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer (default DSIZE=8, NWORDS=4).
module tb_fifo_rd_packer;

    localparam int NWORDS = 4;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rreq;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_cnt;

    fifo_rd_packer dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rreq    (rreq),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_cnt   (m_cnt)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  c;
    } pkt_t;

    pkt_t       exp_q[$];
    logic [7:0] fifo_q[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_hs = -1;
    bit  gap_en = 0;
    bit  gap_ph = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] d, input logic [2:0] c);
        pkt_t p;
        p.d = d;
        p.c = c;
        exp_q.push_back(p);
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + i));
    endtask

    task automatic upd_inputs();
        gap_ph = ~gap_ph;
        rempty = (fifo_q.size() == 0) || (gap_en && gap_ph);
        rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // one cycle: monitor at negedge, apply the edge, update FIFO model
    task automatic tick();
        bit   pop;
        pkt_t e;
        @(negedge rclk);
        pop = rreq;
        if (rempty) chk("rreq_empty", rreq, 0);
        if (m_valid) chk("rreq_hold", rreq, 0);
        if (m_valid && m_ready && !rrst) begin
            if (exp_q.size() == 0) begin
                chk("unexp_pkt", m_data, 64'hdead);
            end else begin
                e = exp_q.pop_front();
                chk("pkt_data", m_data, e.d);
                chk("pkt_cnt", m_cnt, e.c);
            end
            if (last_hs >= 0 && !gap_en) chk("period", cyc - last_hs, NWORDS + 1);
            last_hs = cyc;
        end
        @(posedge rclk);
        #1;
        cyc++;
        if (pop) void'(fifo_q.pop_front());
        upd_inputs();
    endtask

    // reset for one edge, check outputs while still in reset
    task automatic do_reset();
        rrst = 1'b1;
        tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_cnt", m_cnt, 0);
        chk("rst_rreq", rreq, 0);
        rrst = 1'b0;
        last_hs = -1;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!m_valid && n < max) begin
            tick();
            n++;
        end
        chk("wait_valid", m_valid, 1);
    endtask

    initial begin
        rrst    = 1'b1;
        m_ready = 1'b0;
        rempty  = 1'b1;
        rdata   = 8'h00;
        fifo_q.delete();
        do_reset();

        // stream of 1..16 with m_ready high
        m_ready = 1'b1;
        push_words(1, 16);
        exp_push(32'h04030201, 3'd4);
        exp_push(32'h08070605, 3'd4);
        exp_push(32'h0C0B0A09, 3'd4);
        exp_push(32'h100F0E0D, 3'd4);
        upd_inputs();
        drain(60);
        tick();
        tick();
        chk("stream_rreq_idle", rreq, 0);
        chk("stream_fifo_empty", fifo_q.size(), 0);

        // backpressure after first packet
        do_reset();
        m_ready = 1'b0;
        push_words(1, 8);
        exp_push(32'h04030201, 3'd4);
        exp_push(32'h08070605, 3'd4);
        upd_inputs();
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data", m_data, 32'h04030201);
            chk("bp_valid", m_valid, 1);
        end
        m_ready = 1'b1;
        last_hs = -1;
        drain(40);
        chk("bp_fifo_empty", fifo_q.size(), 0);

        // rempty gaps mid-packet
        do_reset();
        gap_en = 1'b1;
        push_words(1, 8);
        exp_push(32'h04030201, 3'd4);
        exp_push(32'h08070605, 3'd4);
        upd_inputs();
        drain(80);
        gap_en = 1'b0;

        // partial packet with idle FIFO
        do_reset();
        m_ready = 1'b0;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        upd_inputs();
        for (int i = 0; i < 20 && fifo_q.size() != 0; i++) tick();
        chk("tmo_popped", fifo_q.size(), 0);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_early", m_valid, 0);
        tick();
        chk("tmo_valid", m_valid, 1);
        chk("tmo_data", m_data, 32'h0000BBAA);
        chk("tmo_cnt", m_cnt, 2);
        exp_push(32'h0000BBAA, 3'd2);
        m_ready = 1'b1;
        drain(5);
`else
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        chk("no_flush", m_valid, 0);
`endif

        // reset mid-packet discards popped words
        do_reset();
        m_ready = 1'b1;
        push_words(1, 2);
        upd_inputs();
        for (int i = 0; i < 10 && fifo_q.size() != 0; i++) tick();
        do_reset();
        push_words(5, 4);
        exp_push(32'h08070605, 3'd4);
        upd_inputs();
        drain(20);
        for (int i = 0; i < 5; i++) tick();

        // reset while holding a packet
        do_reset();
        m_ready = 1'b0;
        push_words(1, 4);
        upd_inputs();
        wait_valid(20);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("hold_rst_valid", m_valid, 0);
        chk("exp_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
